// File: rtl/hex_scan_display_if.sv
// Bundle between the game-logic core / board pins and hex_scan_display.
// Carries the captured nibble strobe, buffer clear and the multiplexed display drive.
// master = nibble producer and display observer, slave = hex_scan_display.
interface hex_scan_display_if;
    logic [3:0] nib;        // nibble from the core's to_vdc
    logic       nib_valid;  // capture strobe, one nibble per high cycle
    logic       clear;      // synchronous clear of the digit buffer
    logic [3:0] an;         // digit enables, active-low, an[0] = rightmost
    logic [6:0] seg;        // {g,f,e,d,c,b,a}, active-low
    logic       dp;         // decimal point, active-low, always off

    modport master (
        output nib,
        output nib_valid,
        output clear,
        input  an,
        input  seg,
        input  dp
    );

    modport slave (
        input  nib,
        input  nib_valid,
        input  clear,
        output an,
        output seg,
        output dp
    );
endinterface

// File: rtl/hex_scan_display.sv
// Captures to_vdc nibbles into a 4-digit shift buffer and scans it onto a
// common-anode 4-digit seven-segment display (an/seg/dp active-low).
// Latency: captured nibble visible in the buffer after 1 edge, on seg 1 edge later
// (when its digit is selected). No backpressure: every strobe is taken.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero digits (d0 never blanked).
module hex_scan_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst,     // asynchronous, active-low
    hex_scan_display_if.slave bus
);

    // Divider width: ceil(log2(REFRESH_DIV)), never below one bit.
    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(REFRESH_DIV - 1);

    // Scan ring: one state per digit position, state value doubles as digit index.
    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } scan_state_t;

    scan_state_t      state_q, state_d;
    logic [DIV_W-1:0] div_q,   div_d;
    logic [3:0][3:0]  dig_q,   dig_d;
    logic [3:0]       an_q,    an_d;
    logic [6:0]       seg_q,   seg_d;
    logic             div_wrap;
    logic [3:0]       blank;

    // Hex to active-low {g,f,e,d,c,b,a} segment pattern.
    function automatic logic [6:0] hex_decode(input logic [3:0] val);
        logic [6:0] s;
        case (val)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Digit buffer next state: clear dominates, otherwise shift in on strobe.
    always_comb begin
        dig_d = dig_q;
        if (bus.clear) begin
            dig_d = '0;
        end else if (bus.nib_valid) begin
            dig_d[3] = dig_q[2];
            dig_d[2] = dig_q[1];
            dig_d[1] = dig_q[0];
            dig_d[0] = bus.nib;
        end
    end

    // Refresh divider: 0..REFRESH_DIV-1, wrap pulse advances the scan.
    always_comb begin
        div_wrap = (div_q == DIV_MAX);
        div_d    = div_wrap ? '0 : div_q + 1'b1;
    end

    // Scan ring next state: hold the current digit until the divider wraps.
    always_comb begin
        state_d = state_q;
        if (div_wrap) begin
            case (state_q)
                DIG0:    state_d = DIG1;
                DIG1:    state_d = DIG2;
                DIG2:    state_d = DIG3;
                default: state_d = DIG0;
            endcase
        end
    end

    // Leading-zero mask: a digit is blank when it and every digit above it are zero.
    always_comb begin
        blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
        blank[3] = (dig_q[3] == 4'h0);
        blank[2] = blank[3] && (dig_q[2] == 4'h0);
        blank[1] = blank[2] && (dig_q[1] == 4'h0);
        blank[0] = 1'b0;
`endif
    end

    // Output stage inputs: select the active digit from the current scan state.
    always_comb begin
        an_d  = ~(4'b0001 << state_q);
        seg_d = blank[state_q] ? 7'b1111111 : hex_decode(dig_q[state_q]);
    end

    // Data path and scan registers; reset leaves the buffer zero and the scan at digit 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dig_q   <= '0;
            div_q   <= '0;
            state_q <= DIG0;
        end else begin
            dig_q   <= dig_d;
            div_q   <= div_d;
            state_q <= state_d;
        end
    end

    // Registered display drive; dark while in reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an_q  <= 4'b1111;
            seg_q <= 7'b1111111;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = 1'b1;

endmodule
